// File: rtl/add_ctrl.sv
// add_ctrl: sequencing controller for the add vector datapath.
// Accepts one LANES-wide operand pair, steps one shared 32-bit adder across the
// lanes (one lane per cycle), then returns the result over a valid/ready channel.
//
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   req_valid/req_ready   request handshake; req_a/req_b operand vectors
//   rsp_valid/rsp_ready   response handshake; rsp_y result vector
//   busy                  operation in progress (RUN or DONE)
//   cc                    cycles spent in RUN since reset (wrapping)
//   done_cnt              completed response handshakes since reset (wrapping)
module add_ctrl #(
  parameter int unsigned LANES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [32*LANES-1:0]   req_a,
  input  logic [32*LANES-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [32*LANES-1:0]   rsp_y,
  output logic                  busy,
  output logic [31:0]           cc,
  output logic [31:0]           done_cnt
);

  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [32*LANES-1:0]   ra_q, rb_q, ry_q;
  logic [32*LANES-1:0]   ry_next;
  logic [IdxW-1:0]       idx_q;
  logic [31:0]           cc_q, done_cnt_q;
  logic                  req_fire, rsp_fire;

  assign rsp_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  // Held low during reset so nothing can be accepted while the state is being cleared.
  assign req_ready = !reset && ((state_q == StIdle) || ((state_q == StDone) && rsp_ready));
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign rsp_y     = ry_q;
  assign cc        = cc_q;
  assign done_cnt  = done_cnt_q;

  // Shared adder: only the lane selected by idx is updated; the carry out is dropped.
  always_comb begin
    ry_next = ry_q;
    for (int i = 0; i < int'(LANES); i++) begin
      if (idx_q == IdxW'(i)) begin
        ry_next[32*i +: 32] = ra_q[32*i +: 32] + rb_q[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire) state_d = StRun;
      end
      StRun: begin
        if (idx_q == LastIdx) state_d = StDone;
      end
      StDone: begin
        if (rsp_fire) state_d = req_fire ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ra_q       <= '0;
      rb_q       <= '0;
      ry_q       <= '0;
      idx_q      <= '0;
      cc_q       <= '0;
      done_cnt_q <= '0;
    end else begin
      // A request can only fire in IDLE or DONE, so it never collides with a RUN step.
      if (req_fire) begin
        ra_q  <= req_a;
        rb_q  <= req_b;
        ry_q  <= '0;
        idx_q <= '0;
      end else if (state_q == StRun) begin
        ry_q <= ry_next;
        if (idx_q != LastIdx) idx_q <= idx_q + IdxW'(1);
      end
      if (state_q == StRun) cc_q <= cc_q + 32'd1;
      if (rsp_fire) done_cnt_q <= done_cnt_q + 32'd1;
    end
  end

endmodule
